// File: rtl/operand_stage.sv
`default_nettype none
// ============================================================================
// operand_stage: operand fetch with register scoreboard and hazard stall.
// Optional OPERAND_BYPASS_EN forwards same-cycle writeback data to operands.
// Revision: 1.0
// ============================================================================
module operand_stage #(
   parameter int DATA_W = 32,
   parameter int AW     = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iValid,
   output logic              oReady,
   input  logic [AW-1:0]     iRs1,
   input  logic [AW-1:0]     iRs2,
   input  logic [AW-1:0]     iRd,
   input  logic              iRdWe,
   output logic [AW-1:0]     oRAddr1,
   output logic [AW-1:0]     oRAddr2,
   input  logic [DATA_W-1:0] iRData1,
   input  logic [DATA_W-1:0] iRData2,
   input  logic [AW-1:0]     iWAddr,
   input  logic [DATA_W-1:0] iWData,
   input  logic              iWe,
   input  logic              iFlush,
   output logic              oValid,
   input  logic              iReady,
   output logic [DATA_W-1:0] oOp1,
   output logic [DATA_W-1:0] oOp2,
   output logic [AW-1:0]     oRd,
   output logic              oRdWe
);

   localparam int NREG = 1 << AW;

   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_nxt;
   logic              wb_hit1;
   logic              wb_hit2;
   logic              src1_busy;
   logic              src2_busy;
   logic              inflight_hit;
   logic              hazard;
   logic              accept;
   logic              handoff;
   logic [DATA_W-1:0] op1_sel;
   logic [DATA_W-1:0] op2_sel;

   assign oRAddr1 = iRs1;
   assign oRAddr2 = iRs2;

   assign wb_hit1 = iWe && (iWAddr == iRs1);
   assign wb_hit2 = iWe && (iWAddr == iRs2);

`ifdef OPERAND_BYPASS_EN
   assign src1_busy = busy[iRs1] && !wb_hit1;
   assign src2_busy = busy[iRs2] && !wb_hit2;
   assign op1_sel   = wb_hit1 ? iWData : iRData1;
   assign op2_sel   = wb_hit2 ? iWData : iRData2;
`else
   // The register file only shows a write after the edge, so a source being
   // written this cycle must wait one more cycle.
   logic unused_wdata;
   assign unused_wdata = ^iWData;
   assign src1_busy    = busy[iRs1] || wb_hit1;
   assign src2_busy    = busy[iRs2] || wb_hit2;
   assign op1_sel      = iRData1;
   assign op2_sel      = iRData2;
`endif

   // The held instruction has not yet marked its destination busy.
   assign inflight_hit = oValid && oRdWe &&
                         ((oRd == iRs1) || (oRd == iRs2) || (iRdWe && (oRd == iRd)));

   assign hazard  = iValid && (src1_busy || src2_busy || (iRdWe && busy[iRd]) || inflight_hit);
   assign oReady  = !reset && !hazard && (!oValid || iReady) && !iFlush;
   assign accept  = iValid && oReady;
   assign handoff = oValid && iReady && !iFlush;

   // Set is applied after clear so a same-register collision leaves it busy.
   always_comb begin
      busy_nxt = busy;
      if (iWe) begin
         busy_nxt[iWAddr] = 1'b0;
      end
      if (handoff && oRdWe) begin
         busy_nxt[oRd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy   <= '0;
         oValid <= 1'b0;
         oOp1   <= '0;
         oOp2   <= '0;
         oRd    <= '0;
         oRdWe  <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (accept) begin
            oValid <= 1'b1;
            oOp1   <= op1_sel;
            oOp2   <= op2_sel;
            oRd    <= iRd;
            oRdWe  <= iRdWe;
         end else if (iFlush || iReady) begin
            oValid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_operand_stage.sv
`default_nettype none
// Scoreboard bench for operand_stage: per-scenario tasks with a behavioural register file.
module tb_operand_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        iValid;
   logic        oReady;
   logic [4:0]  iRs1, iRs2, iRd;
   logic        iRdWe;
   logic [4:0]  oRAddr1, oRAddr2;
   logic [31:0] iRData1, iRData2;
   logic [4:0]  iWAddr;
   logic [31:0] iWData;
   logic        iWe;
   logic        iFlush;
   logic        oValid;
   logic        iReady;
   logic [31:0] oOp1, oOp2;
   logic [4:0]  oRd;
   logic        oRdWe;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        rdwe;
   } exp_t;

   exp_t sbq[$];
   exp_t e, got;
   int   vectors = 0;
   int   miscompares = 0;
   logic [31:0] rf [32];

   always #5 clk = ~clk;

   operand_stage #(.DATA_W(32), .AW(5)) dut (
      .clk(clk), .reset(reset), .iValid(iValid), .oReady(oReady),
      .iRs1(iRs1), .iRs2(iRs2), .iRd(iRd), .iRdWe(iRdWe),
      .oRAddr1(oRAddr1), .oRAddr2(oRAddr2), .iRData1(iRData1), .iRData2(iRData2),
      .iWAddr(iWAddr), .iWData(iWData), .iWe(iWe), .iFlush(iFlush),
      .oValid(oValid), .iReady(iReady), .oOp1(oOp1), .oOp2(oOp2),
      .oRd(oRd), .oRdWe(oRdWe)
   );

   function automatic logic [31:0] iv(input int i);
      if (i == 3) return 32'h11;
      if (i == 4) return 32'h22;
      return 32'h1000_0000 + 32'(i) * 32'h101;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= iv(i);
      end else if (iWe) begin
         rf[iWAddr] <= iWData;
      end
   end
   assign iRData1 = rf[oRAddr1];
   assign iRData2 = rf[oRAddr2];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iValid = 1'b0; iRs1 = '0; iRs2 = '0; iRd = '0; iRdWe = 1'b0;
      iWAddr = '0; iWData = '0; iWe = 1'b0; iFlush = 1'b0; iReady = 1'b1;
   endtask

   task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rdwe);
      iValid = 1'b1; iRs1 = rs1; iRs2 = rs2; iRd = rd; iRdWe = rdwe;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      offer(5'd1, 5'd2, 5'd3, 1'b1);
      cyc();
      vectors++;
      if (oReady !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b, required 0", oReady); end
      cyc();
      reset = 1'b0;
      iValid = 1'b0;
      #1;
      got = {oOp1, oOp2, oRd, oRdWe};
      vectors++;
      if (oValid !== 1'b0 || got !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got oValid=%b outs=%h, required oValid=0 outs=0", oValid, got);
      end
   endtask

   task automatic test_basic();
      idle();
      offer(5'd3, 5'd4, 5'd9, 1'b0);
      #1;
      vectors++;
      if (oReady !== 1'b1) begin miscompares++; $display("FAIL basic_ready: got %b, required 1", oReady); end
      sbq.push_back('{32'h11, 32'h22, 5'd9, 1'b0});
      cyc();
      iValid = 1'b0;
      #1;
      vectors++;
      if (oValid !== 1'b1 || sbq.size() == 0) begin miscompares++; $display("FAIL basic_out: oValid=%b queued=%0d, required 1 with entry", oValid, sbq.size()); end
      else begin e = sbq.pop_front(); got = {oOp1, oOp2, oRd, oRdWe};
         if (got !== e) begin miscompares++; $display("FAIL basic_out: got %h, required %h", got, e); end end
      cyc();
      vectors++;
      if (oValid !== 1'b0) begin miscompares++; $display("FAIL basic_drain: oValid=%b, required 0", oValid); end
   endtask

   task automatic test_back_to_back();
      idle();
      for (int k = 0; k < 5; k++) begin
         if (k < 4) offer(5'(k + 1), 5'(k + 5), 5'(24 + k), 1'b0);
         else iValid = 1'b0;
         #1;
         if (k < 4) begin
            vectors++;
            if (oReady !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b, required 1", k, oReady); end
         end
         if (k > 0) begin
            vectors++;
            if (oValid !== 1'b1 || sbq.size() == 0) begin miscompares++; $display("FAIL b2b_out[%0d]: oValid=%b queued=%0d, required 1 with entry", k, oValid, sbq.size()); end
            else begin e = sbq.pop_front(); got = {oOp1, oOp2, oRd, oRdWe};
               if (got !== e) begin miscompares++; $display("FAIL b2b_out[%0d]: got %h, required %h", k, got, e); end end
         end
         if (k < 4) sbq.push_back('{iv(k + 1), iv(k + 5), 5'(24 + k), 1'b0});
         cyc();
      end
      vectors++;
      if (oValid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: oValid=%b, required 0", oValid); end
   endtask

   task automatic test_hazard_writeback();
      idle();
      offer(5'd1, 5'd2, 5'd5, 1'b1);
      #1;
      vectors++;
      if (oReady !== 1'b1) begin miscompares++; $display("FAIL hz_a_ready: got %b, required 1", oReady); end
      sbq.push_back('{iv(1), iv(2), 5'd5, 1'b1});
      cyc();
      offer(5'd5, 5'd6, 5'd10, 1'b0);
      #1;
      vectors++;
      if (oReady !== 1'b0) begin miscompares++; $display("FAIL hz_b_inflight: oReady=%b, required 0", oReady); end
      vectors++;
      if (oValid !== 1'b1 || sbq.size() == 0) begin miscompares++; $display("FAIL hz_a_out: oValid=%b queued=%0d, required 1 with entry", oValid, sbq.size()); end
      else begin e = sbq.pop_front(); got = {oOp1, oOp2, oRd, oRdWe};
         if (got !== e) begin miscompares++; $display("FAIL hz_a_out: got %h, required %h", got, e); end end
      for (int k = 0; k < 2; k++) begin
         cyc();
         vectors++;
         if (oReady !== 1'b0) begin miscompares++; $display("FAIL hz_b_busy[%0d]: oReady=%b, required 0", k, oReady); end
      end
      cyc();
      iWe = 1'b1; iWAddr = 5'd5; iWData = 32'hAB;
      #1;
`ifdef OPERAND_BYPASS_EN
      vectors++;
      if (oReady !== 1'b1) begin miscompares++; $display("FAIL hz_b_bypass: oReady=%b, required 1", oReady); end
      sbq.push_back('{32'hAB, iv(6), 5'd10, 1'b0});
      cyc();
      iWe = 1'b0; iValid = 1'b0;
`else
      vectors++;
      if (oReady !== 1'b0) begin miscompares++; $display("FAIL hz_b_wb_stall: oReady=%b, required 0", oReady); end
      cyc();
      iWe = 1'b0;
      #1;
      vectors++;
      if (oReady !== 1'b1) begin miscompares++; $display("FAIL hz_b_after_wb: oReady=%b, required 1", oReady); end
      sbq.push_back('{32'hAB, iv(6), 5'd10, 1'b0});
      cyc();
      iValid = 1'b0;
`endif
      #1;
      vectors++;
      if (oValid !== 1'b1 || sbq.size() == 0) begin miscompares++; $display("FAIL hz_b_out: oValid=%b queued=%0d, required 1 with entry", oValid, sbq.size()); end
      else begin e = sbq.pop_front(); got = {oOp1, oOp2, oRd, oRdWe};
         if (got !== e) begin miscompares++; $display("FAIL hz_b_out: got %h, required %h", got, e); end end
      cyc();
   endtask

   task automatic test_stall();
      idle();
      offer(5'd1, 5'd2, 5'd12, 1'b1);
      #1;
      vectors++;
      if (oReady !== 1'b1) begin miscompares++; $display("FAIL stall_c_ready: got %b, required 1", oReady); end
      sbq.push_back('{iv(1), iv(2), 5'd12, 1'b1});
      cyc();
      offer(5'd8, 5'd9, 5'd13, 1'b0);
      iReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         got = {oOp1, oOp2, oRd, oRdWe};
         vectors++;
         if (oValid !== 1'b1 || got !== sbq[0] || oReady !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: got oValid=%b outs=%h oReady=%b, required 1 %h 0", k, oValid, got, oReady, sbq[0]);
         end
         cyc();
      end
      iReady = 1'b1;
      #1;
      vectors++;
      if (oReady !== 1'b1) begin miscompares++; $display("FAIL stall_release: oReady=%b, required 1", oReady); end
      vectors++;
      if (oValid !== 1'b1 || sbq.size() == 0) begin miscompares++; $display("FAIL stall_c_out: oValid=%b queued=%0d, required 1 with entry", oValid, sbq.size()); end
      else begin e = sbq.pop_front(); got = {oOp1, oOp2, oRd, oRdWe};
         if (got !== e) begin miscompares++; $display("FAIL stall_c_out: got %h, required %h", got, e); end end
      sbq.push_back('{iv(8), iv(9), 5'd13, 1'b0});
      cyc();
      offer(5'd12, 5'd1, 5'd19, 1'b0);
      #1;
      vectors++;
      if (oReady !== 1'b0) begin miscompares++; $display("FAIL stall_busy12: oReady=%b, required 0", oReady); end
      vectors++;
      if (oValid !== 1'b1 || sbq.size() == 0) begin miscompares++; $display("FAIL stall_d_out: oValid=%b queued=%0d, required 1 with entry", oValid, sbq.size()); end
      else begin e = sbq.pop_front(); got = {oOp1, oOp2, oRd, oRdWe};
         if (got !== e) begin miscompares++; $display("FAIL stall_d_out: got %h, required %h", got, e); end end
      cyc();
      iValid = 1'b0; iWe = 1'b1; iWAddr = 5'd12; iWData = 32'h55;
      cyc();
      iWe = 1'b0;
   endtask

   task automatic test_set_wins();
      idle();
      offer(5'd1, 5'd2, 5'd7, 1'b1);
      #1;
      sbq.push_back('{iv(1), iv(2), 5'd7, 1'b1});
      cyc();
      iValid = 1'b0; iWe = 1'b1; iWAddr = 5'd7; iWData = 32'h77;
      #1;
      vectors++;
      if (oValid !== 1'b1 || sbq.size() == 0) begin miscompares++; $display("FAIL sw_f_out: oValid=%b queued=%0d, required 1 with entry", oValid, sbq.size()); end
      else begin e = sbq.pop_front(); got = {oOp1, oOp2, oRd, oRdWe};
         if (got !== e) begin miscompares++; $display("FAIL sw_f_out: got %h, required %h", got, e); end end
      cyc();
      iWe = 1'b0;
      offer(5'd7, 5'd1, 5'd14, 1'b0);
      #1;
      vectors++;
      if (oReady !== 1'b0) begin miscompares++; $display("FAIL sw_busy7: oReady=%b, required 0", oReady); end
      iValid = 1'b0; iWe = 1'b1; iWAddr = 5'd7; iWData = 32'h78;
      cyc();
      iWe = 1'b0;
      offer(5'd7, 5'd1, 5'd14, 1'b0);
      #1;
      vectors++;
      if (oReady !== 1'b1) begin miscompares++; $display("FAIL sw_cleared: oReady=%b, required 1", oReady); end
      sbq.push_back('{32'h78, iv(1), 5'd14, 1'b0});
      cyc();
      iValid = 1'b0;
      #1;
      vectors++;
      if (oValid !== 1'b1 || sbq.size() == 0) begin miscompares++; $display("FAIL sw_g_out: oValid=%b queued=%0d, required 1 with entry", oValid, sbq.size()); end
      else begin e = sbq.pop_front(); got = {oOp1, oOp2, oRd, oRdWe};
         if (got !== e) begin miscompares++; $display("FAIL sw_g_out: got %h, required %h", got, e); end end
      cyc();
   endtask

   task automatic test_flush();
      idle();
      offer(5'd1, 5'd2, 5'd15, 1'b1);
      #1;
      sbq.push_back('{iv(1), iv(2), 5'd15, 1'b1});
      cyc();
      offer(5'd3, 5'd4, 5'd16, 1'b1);
      iFlush = 1'b1;
      #1;
      vectors++;
      if (oReady !== 1'b0) begin miscompares++; $display("FAIL flush_ready: oReady=%b, required 0", oReady); end
      vectors++;
      if (oValid !== 1'b1 || sbq.size() == 0) begin miscompares++; $display("FAIL flush_h_out: oValid=%b queued=%0d, required 1 with entry", oValid, sbq.size()); end
      else begin e = sbq.pop_front(); got = {oOp1, oOp2, oRd, oRdWe};
         if (got !== e) begin miscompares++; $display("FAIL flush_h_out: got %h, required %h", got, e); end end
      cyc();
      iFlush = 1'b0;
      offer(5'd15, 5'd16, 5'd17, 1'b0);
      #1;
      vectors++;
      if (oValid !== 1'b0) begin miscompares++; $display("FAIL flush_ovalid: oValid=%b, required 0", oValid); end
      vectors++;
      if (oReady !== 1'b1) begin miscompares++; $display("FAIL flush_no_busy: oReady=%b, required 1", oReady); end
      sbq.push_back('{iv(15), iv(16), 5'd17, 1'b0});
      cyc();
      iValid = 1'b0;
      #1;
      vectors++;
      if (oValid !== 1'b1 || sbq.size() == 0) begin miscompares++; $display("FAIL flush_j_out: oValid=%b queued=%0d, required 1 with entry", oValid, sbq.size()); end
      else begin e = sbq.pop_front(); got = {oOp1, oOp2, oRd, oRdWe};
         if (got !== e) begin miscompares++; $display("FAIL flush_j_out: got %h, required %h", got, e); end end
      cyc();
   endtask

   task automatic test_reset_mid();
      idle();
      offer(5'd1, 5'd2, 5'd2, 1'b1);
      #1;
      sbq.push_back('{iv(1), iv(2), 5'd2, 1'b1});
      cyc();
      offer(5'd3, 5'd4, 5'd18, 1'b0);
      #1;
      vectors++;
      if (oReady !== 1'b1) begin miscompares++; $display("FAIL rst_l_ready: oReady=%b, required 1", oReady); end
      vectors++;
      if (oValid !== 1'b1 || sbq.size() == 0) begin miscompares++; $display("FAIL rst_k_out: oValid=%b queued=%0d, required 1 with entry", oValid, sbq.size()); end
      else begin e = sbq.pop_front(); got = {oOp1, oOp2, oRd, oRdWe};
         if (got !== e) begin miscompares++; $display("FAIL rst_k_out: got %h, required %h", got, e); end end
      sbq.push_back('{32'h11, 32'h22, 5'd18, 1'b0});
      cyc();
      reset = 1'b1; iValid = 1'b0; iReady = 1'b0;
      #1;
      vectors++;
      if (oValid !== 1'b1) begin miscompares++; $display("FAIL rst_l_held: oValid=%b, required 1", oValid); end
      sbq.delete();
      cyc();
      reset = 1'b0;
      offer(5'd2, 5'd2, 5'd2, 1'b1);
      #1;
      vectors++;
      if (oValid !== 1'b0 || oOp1 !== 32'h0 || oRd !== 5'd0) begin
         miscompares++;
         $display("FAIL rst_mid_state: got oValid=%b oOp1=%h oRd=%0d, required 0 0 0", oValid, oOp1, oRd);
      end
      vectors++;
      if (oReady !== 1'b1) begin miscompares++; $display("FAIL rst_busy_cleared: oReady=%b, required 1", oReady); end
      sbq.push_back('{iv(2), iv(2), 5'd2, 1'b1});
      cyc();
      iValid = 1'b0; iReady = 1'b1;
      #1;
      vectors++;
      if (oValid !== 1'b1 || sbq.size() == 0) begin miscompares++; $display("FAIL rst_m_out: oValid=%b queued=%0d, required 1 with entry", oValid, sbq.size()); end
      else begin e = sbq.pop_front(); got = {oOp1, oOp2, oRd, oRdWe};
         if (got !== e) begin miscompares++; $display("FAIL rst_m_out: got %h, required %h", got, e); end end
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_hazard_writeback();
      test_stall();
      test_set_wins();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and writeback data width.
REQ-002 SHALL have parameter AW, default 5, register address width (32 registers).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL have ports iValid/oReady  input/output  1/1  upstream decoded-instruction handshake.
REQ-006 SHALL have ports iRs1, iRs2, iRd  input  AW each  source and destination register addresses.
REQ-007 SHALL have port iRdWe  input  1  the instruction writes iRd.
REQ-008 SHALL have ports oRAddr1, oRAddr2  output  AW each  register-file read addresses, wired combinationally from iRs1/iRs2.
REQ-009 SHALL have ports iRData1, iRData2  input  DATA_W each  combinational register-file read data.
REQ-010 SHALL have ports iWAddr, iWData, iWe  input  AW/DATA_W/1  writeback bus, identical to the register-file write port.
REQ-011 SHALL have port iFlush  input  1  kill the held instruction and the one offered this cycle.
REQ-012 SHALL have ports oValid/iReady  output/input  1/1  downstream execute handshake.
REQ-013 SHALL have ports oOp1, oOp2  output  DATA_W each, and oRd  output  AW, and oRdWe  output  1, all registered.

Function
REQ-014 SHALL hold a 32-bit scoreboard busy[], one bit per register; register 0 is an ordinary register.
REQ-015 SHALL raise hazard when iValid and any of: busy[iRs1], busy[iRs2], iRdWe and busy[iRd], or oValid and oRdWe and oRd matching iRs1, iRs2, or (when iRdWe) iRd.
REQ-016 SHALL exclude from hazard a busy source register whose writeback is on the bus this cycle (iWe and iWAddr equal to it), when BYPASS_EN is defined.
REQ-017 SHALL drive oReady = !hazard and (!oValid or iReady) and !iFlush, combinationally.
REQ-018 SHALL accept on iValid and oReady: next cycle oValid=1, oOp1/oOp2 = operand values, oRd=iRd, oRdWe=iRdWe; latency one cycle.
REQ-019 SHALL, when oValid and iReady and no accept, clear oValid on the next edge.
REQ-020 SHALL hold oValid and oOp1/oOp2/oRd/oRdWe stable while oValid and !iReady.
REQ-021 SHALL, on handoff (oValid and iReady and !iFlush and oRdWe), set busy[oRd] on the same edge.
REQ-022 SHALL, on iWe, clear busy[iWAddr]; if a set and a clear hit the same register on one edge, the set wins.
REQ-023 SHALL, on iFlush, clear oValid next edge, accept nothing, and leave busy[] untouched except for writeback clears.
REQ-024 SHALL support full throughput: one accept per cycle when there is no hazard and iReady=1.

Reset
REQ-025 SHALL, on reset, set oValid=0, oOp1=oOp2=0, oRd=0, oRdWe=0, and all busy[] bits to 0 on that edge.
REQ-026 SHALL give reset priority over iFlush, accept, handoff and writeback; it drops any in-flight instruction.
REQ-027 SHALL drive oReady=0 during the cycle in which reset is asserted.

Configuration
REQ-028 SHALL, with macro OPERAND_BYPASS_EN defined, select iWData for an operand when iWe and iWAddr equals that source address; otherwise it selects iRData1/iRData2.
REQ-029 SHALL, without OPERAND_BYPASS_EN, take operands only from iRData1/iRData2 and add to hazard any source address equal to iWAddr while iWe=1.
REQ-030 SHALL, without OPERAND_BYPASS_EN, stall a dependent instruction for exactly one extra cycle relative to the bypassed build.

Verification
REQ-031 SHALL cover: reset, then iValid with rs1=3, rs2=4 (regfile values 0x11, 0x22), iReady=1 -> next cycle oValid=1, oOp1=0x11, oOp2=0x22.
REQ-032 SHALL cover: instruction A writes r5, handed off, then B reads r5 -> oReady=0 until iWe with iWAddr=5 and iWData=0xAB; with bypass, B is accepted that cycle with oOp1=0xAB; without bypass, one cycle later.
REQ-033 SHALL cover: oValid=1, iReady=0 for 3 cycles -> outputs stable, oReady=0; iReady=1 -> handoff and busy[oRd] set.
REQ-034 SHALL cover: handoff setting busy[7] on the same edge as iWe with iWAddr=7 -> busy[7]=1 afterwards.
REQ-035 SHALL cover: iFlush with oValid=1 and iValid=1 -> next cycle oValid=0, no busy bit set, and the offered instruction is not accepted.
REQ-036 SHALL cover: reset asserted with busy[2]=1 and oValid=1 -> next cycle all busy[] bits 0, oValid=0, oOp1=0.
